// File: rtl/stream_mux_n.sv
`default_nettype none
// ============================================================================
// Module      : stream_mux_n
// Description : N-channel valid/ready stream mux with a registered select and
//               one output register stage (1-cycle latency, full throughput).
//               Optional beat counter enabled by STREAM_MUX_XFER_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_mux_n #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    localparam int SEL_W = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SEL_W-1:0]   sel,
    input  logic               sel_load,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SEL_W-1:0]   cur_sel,
    output logic               sel_err
`ifdef STREAM_MUX_XFER_CNT_EN
    ,
    output logic [15:0]        xfer_cnt
`endif
);

    localparam logic [SEL_W:0] c_NUM_CH = (SEL_W+1)'(N);

    logic [WIDTH-1:0] w_ch_data [N];
    logic             w_slot_free;
    logic             w_accept;
    logic             w_sel_ok;

    logic [SEL_W-1:0] sel_q,   sel_d;
    logic             err_q,   err_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic             valid_q, valid_d;

    genvar k;
    generate
        for (k = 0; k < N; k++) begin : g_unpack
            assign w_ch_data[k] = in_data[k*WIDTH +: WIDTH];
        end
    endgenerate

    // The output slot can take a beat when empty or being drained this cycle.
    assign w_slot_free = ~valid_q | out_ready;
    assign w_accept    = in_valid[sel_q] & w_slot_free;
    assign w_sel_ok    = {1'b0, sel} < c_NUM_CH;
    assign in_ready    = {{(N-1){1'b0}}, w_slot_free} << sel_q;

    always_comb begin
        sel_d   = sel_q;
        err_d   = err_q;
        data_d  = data_q;
        valid_d = valid_q;
        if (w_accept) begin
            data_d  = w_ch_data[sel_q];
            valid_d = 1'b1;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
        // Acceptance above already used the old select; the new one takes effect next cycle.
        if (sel_load) begin
            if (w_sel_ok) begin
                sel_d = sel;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q   <= '0;
            err_q   <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            sel_q   <= sel_d;
            err_q   <= err_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign cur_sel   = sel_q;
    assign sel_err   = err_q;

`ifdef STREAM_MUX_XFER_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    assign cnt_d = cnt_q + 16'(w_accept);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign xfer_cnt = cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stream_mux_n.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_mux_n
// Description : Self-checking bench for stream_mux_n (N=4 and N=3 instances).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_mux_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // N=4 instance
    logic        rst4 = 1'b1, ld4 = 1'b0, or4 = 1'b1, ov4, err4;
    logic [1:0]  sel4 = 2'd0, cs4;
    logic [31:0] d4 = 32'd0;
    logic [3:0]  v4 = 4'd0, rdy4;
    logic [7:0]  od4;
    // N=3 instance
    logic        rst3 = 1'b1, ld3 = 1'b0, or3 = 1'b1, ov3, err3;
    logic [1:0]  sel3 = 2'd0, cs3;
    logic [23:0] d3 = 24'd0;
    logic [2:0]  v3 = 3'd0, rdy3;
    logic [7:0]  od3;
`ifdef STREAM_MUX_XFER_CNT_EN
    logic [15:0] cnt4, cnt3;
`endif

    stream_mux_n #(.WIDTH(8), .N(4)) u_dut4 (
        .clk(clk), .rst(rst4), .sel(sel4), .sel_load(ld4),
        .in_data(d4), .in_valid(v4), .in_ready(rdy4),
        .out_data(od4), .out_valid(ov4), .out_ready(or4),
        .cur_sel(cs4), .sel_err(err4)
`ifdef STREAM_MUX_XFER_CNT_EN
        , .xfer_cnt(cnt4)
`endif
    );

    stream_mux_n #(.WIDTH(8), .N(3)) u_dut3 (
        .clk(clk), .rst(rst3), .sel(sel3), .sel_load(ld3),
        .in_data(d3), .in_valid(v3), .in_ready(rdy3),
        .out_data(od3), .out_valid(ov3), .out_ready(or3),
        .cur_sel(cs3), .sel_err(err3)
`ifdef STREAM_MUX_XFER_CNT_EN
        , .xfer_cnt(cnt3)
`endif
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: one output slot plus an ordered queue of accepted beats.
    int         m_sel [2];
    bit         m_ov  [2];
    bit         m_err [2];
    logic [7:0] m_od  [2];
    logic [7:0] q0[$];
    logic [7:0] q1[$];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_sel[i] = 0; m_ov[i] = 1'b0; m_err[i] = 1'b0; m_od[i] = 8'd0;
        end
        q0.delete(); q1.delete();
    endtask

    task automatic model_pre(input int i, input int nch, input logic [1:0] s, input logic ld,
                             input logic [31:0] data, input logic [3:0] vld, input logic ordy,
                             input logic [3:0] act_rdy, input logic [7:0] act_od);
        bit         slot;
        bit         acc;
        logic [7:0] b;
        logic [7:0] front;
        slot = !m_ov[i] || ordy;
        chk($sformatf("rand%0d in_ready", i), {28'd0, act_rdy}, slot ? (32'd1 << m_sel[i]) : 32'd0);
        if (m_ov[i] && ordy) begin
            if ((i == 0 ? q0.size() : q1.size()) == 0) begin
                n_chk++;
                $display("FAIL rand%0d deliver: beat delivered with empty scoreboard", i);
            end else begin
                front = (i == 0) ? q0.pop_front() : q1.pop_front();
                chk($sformatf("rand%0d deliver", i), {24'd0, act_od}, {24'd0, front});
            end
        end
        acc = vld[m_sel[i]] && slot;
        b   = data[m_sel[i]*8 +: 8];
        if (acc) begin
            if (i == 0) q0.push_back(b); else q1.push_back(b);
            m_od[i] = b;
            m_ov[i] = 1'b1;
        end else if (ordy) begin
            m_ov[i] = 1'b0;
        end
        if (ld) begin
            if (int'(s) < nch) m_sel[i] = int'(s);
            else m_err[i] = 1'b1;
        end
    endtask

    task automatic model_post(input int i, input logic [7:0] od, input logic ov,
                              input logic [1:0] cs, input logic err);
        chk($sformatf("rand%0d out_data", i),  {24'd0, od}, {24'd0, m_od[i]});
        chk($sformatf("rand%0d out_valid", i), {31'd0, ov}, {31'd0, m_ov[i]});
        chk($sformatf("rand%0d cur_sel", i),   {30'd0, cs}, 32'(m_sel[i]));
        chk($sformatf("rand%0d sel_err", i),   {31'd0, err}, {31'd0, m_err[i]});
    endtask

    typedef struct {
        logic        rst;
        logic [1:0]  sel;
        logic        ld;
        logic [31:0] data;
        logic [3:0]  vld;
        logic        ordy;
        logic [3:0]  e_rdy;
        logic [7:0]  e_od;
        logic        e_ov;
        logic [1:0]  e_cs;
        logic        e_err;
    } vec_t;

    localparam int NV = 17;
    vec_t tbl [NV];

    initial begin
        //               rst   sel   ld    data           vld      ordy  e_rdy    e_od   e_ov  e_cs  e_err
        tbl[0]  = '{1'b0, 2'd2, 1'b1, 32'h00000000, 4'b0000, 1'b1, 4'b0001, 8'h00, 1'b0, 2'd0, 1'b0};
        tbl[0].e_cs = 2'd2;
        tbl[1]  = '{1'b0, 2'd0, 1'b0, 32'h00110000, 4'b0100, 1'b1, 4'b0100, 8'h11, 1'b1, 2'd2, 1'b0};
        tbl[2]  = '{1'b0, 2'd0, 1'b0, 32'h00220000, 4'b0100, 1'b1, 4'b0100, 8'h22, 1'b1, 2'd2, 1'b0};
        tbl[3]  = '{1'b0, 2'd0, 1'b0, 32'h00330000, 4'b0100, 1'b1, 4'b0100, 8'h33, 1'b1, 2'd2, 1'b0};
        tbl[4]  = '{1'b0, 2'd0, 1'b0, 32'hAB000000, 4'b1000, 1'b1, 4'b0100, 8'h33, 1'b0, 2'd2, 1'b0};
        tbl[5]  = '{1'b0, 2'd0, 1'b0, 32'h00A50000, 4'b0100, 1'b0, 4'b0100, 8'hA5, 1'b1, 2'd2, 1'b0};
        tbl[6]  = '{1'b0, 2'd0, 1'b0, 32'h005A0000, 4'b0100, 1'b0, 4'b0000, 8'hA5, 1'b1, 2'd2, 1'b0};
        tbl[7]  = '{1'b0, 2'd0, 1'b0, 32'h005A0000, 4'b0100, 1'b0, 4'b0000, 8'hA5, 1'b1, 2'd2, 1'b0};
        tbl[8]  = '{1'b0, 2'd0, 1'b0, 32'h005A0000, 4'b0100, 1'b1, 4'b0100, 8'h5A, 1'b1, 2'd2, 1'b0};
        tbl[9]  = '{1'b0, 2'd0, 1'b0, 32'h00000000, 4'b0000, 1'b1, 4'b0100, 8'h5A, 1'b0, 2'd2, 1'b0};
        tbl[10] = '{1'b0, 2'd1, 1'b1, 32'h00770000, 4'b0100, 1'b1, 4'b0100, 8'h77, 1'b1, 2'd1, 1'b0};
        tbl[11] = '{1'b0, 2'd0, 1'b0, 32'h00EE9900, 4'b0110, 1'b1, 4'b0010, 8'h99, 1'b1, 2'd1, 1'b0};
        tbl[12] = '{1'b0, 2'd0, 1'b0, 32'h00EE0000, 4'b0100, 1'b1, 4'b0010, 8'h99, 1'b0, 2'd1, 1'b0};
        tbl[13] = '{1'b0, 2'd0, 1'b0, 32'h00004400, 4'b0010, 1'b0, 4'b0010, 8'h44, 1'b1, 2'd1, 1'b0};
        tbl[14] = '{1'b1, 2'd0, 1'b0, 32'h00005500, 4'b0010, 1'b0, 4'b0000, 8'h00, 1'b0, 2'd0, 1'b0};
        tbl[15] = '{1'b1, 2'd0, 1'b0, 32'hFFFFFFFF, 4'b1111, 1'b1, 4'b0001, 8'h00, 1'b0, 2'd0, 1'b0};
        tbl[16] = '{1'b0, 2'd0, 1'b0, 32'h00000000, 4'b0000, 1'b1, 4'b0001, 8'h00, 1'b0, 2'd0, 1'b0};

        // Initial reset of both instances.
        repeat (2) @(posedge clk);
        #1;
        chk("reset out_valid", {31'd0, ov4}, 32'd0);
        chk("reset in_ready",  {28'd0, rdy4}, 32'd1);

        // Directed table on the N=4 instance.
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rst4 = tbl[i].rst; sel4 = tbl[i].sel; ld4 = tbl[i].ld;
            d4 = tbl[i].data; v4 = tbl[i].vld; or4 = tbl[i].ordy;
            #1 chk($sformatf("vec%0d in_ready", i), {28'd0, rdy4}, {28'd0, tbl[i].e_rdy});
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d out_data", i),  {24'd0, od4},  {24'd0, tbl[i].e_od});
            chk($sformatf("vec%0d out_valid", i), {31'd0, ov4},  {31'd0, tbl[i].e_ov});
            chk($sformatf("vec%0d cur_sel", i),   {30'd0, cs4},  {30'd0, tbl[i].e_cs});
            chk($sformatf("vec%0d sel_err", i),   {31'd0, err4}, {31'd0, tbl[i].e_err});
        end

        // Out-of-range select and unselected-channel ignore on the N=3 instance.
        @(negedge clk);
        rst3 = 1'b0; ld3 = 1'b1; sel3 = 2'd1; v3 = 3'd0; or3 = 1'b1;
        @(posedge clk); #1;
        chk("n3 load1 cur_sel", {30'd0, cs3}, 32'd1);
        chk("n3 load1 sel_err", {31'd0, err3}, 32'd0);
        @(negedge clk);
        sel3 = 2'd3;
        @(posedge clk); #1;
        chk("n3 bad load cur_sel", {30'd0, cs3}, 32'd1);
        chk("n3 bad load sel_err", {31'd0, err3}, 32'd1);
        @(negedge clk);
        ld3 = 1'b0; v3 = 3'b001; d3 = 24'h0000C3;
        #1 chk("n3 in_ready", {29'd0, rdy3}, 32'b010);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("n3 ignore out_valid", {31'd0, ov3}, 32'd0);
            chk("n3 ignore out_data",  {24'd0, od3}, 32'd0);
            chk("n3 sticky sel_err",   {31'd0, err3}, 32'd1);
        end
        @(negedge clk);
        ld3 = 1'b1; sel3 = 2'd0; v3 = 3'd0;
        @(posedge clk); #1;
        chk("n3 reload cur_sel", {30'd0, cs3}, 32'd0);
        chk("n3 reload sel_err", {31'd0, err3}, 32'd1);

        // Randomized traffic on both instances against the reference model.
        @(negedge clk);
        rst4 = 1'b1; rst3 = 1'b1; ld4 = 1'b0; ld3 = 1'b0; v4 = 4'd0; v3 = 3'd0;
        @(posedge clk);
        model_reset();
        @(negedge clk);
        rst4 = 1'b0; rst3 = 1'b0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if (cyc != 0) @(negedge clk);
            sel4 = 2'($urandom_range(0, 3)); ld4 = ($urandom_range(0, 7) == 0);
            d4 = $urandom; v4 = 4'($urandom); or4 = ($urandom_range(0, 9) < 7);
            sel3 = 2'($urandom_range(0, 3)); ld3 = ($urandom_range(0, 15) == 0);
            d3 = 24'($urandom); v3 = 3'($urandom); or3 = ($urandom_range(0, 9) < 6);
            #1;
            model_pre(0, 4, sel4, ld4, d4, v4, or4, rdy4, od4);
            model_pre(1, 3, sel3, ld3, {8'd0, d3}, {1'b0, v3}, or3, {1'b0, rdy3}, od3);
            @(posedge clk); #1;
            model_post(0, od4, ov4, cs4, err4);
            model_post(1, od3, ov3, cs3, err3);
        end

`ifdef STREAM_MUX_XFER_CNT_EN
        // Beat counter wrap on the N=4 instance.
        @(negedge clk);
        rst4 = 1'b1; ld4 = 1'b0;
        @(posedge clk); #1;
        chk("cnt reset", {16'd0, cnt4}, 32'd0);
        @(negedge clk);
        rst4 = 1'b0; v4 = 4'b0001; or4 = 1'b1; d4 = 32'h0;
        repeat (65535) @(posedge clk);
        #1 chk("cnt FFFF", {16'd0, cnt4}, 32'h0000FFFF);
        @(posedge clk); #1 chk("cnt wrap 0000", {16'd0, cnt4}, 32'h00000000);
        @(posedge clk); #1 chk("cnt 0001", {16'd0, cnt4}, 32'h00000001);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
